// File: rtl/tvip_axi_sample_memory_slave.sv
// AXI4 memory responder: independent write and read burst engines over a word-addressed array.
// Responds OKAY, SLVERR (bad burst/size/wlast) or DECERR (beat beyond MEM_DEPTH).
module tvip_axi_sample_memory_slave #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_awvalid,
    output logic                      o_awready,
    input  logic [ID_WIDTH-1:0]       i_awid,
    input  logic [ADDR_WIDTH-1:0]     i_awaddr,
    input  logic [7:0]                i_awlen,
    input  logic [2:0]                i_awsize,
    input  logic [1:0]                i_awburst,
    input  logic                      i_wvalid,
    output logic                      o_wready,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    input  logic                      i_wlast,
    output logic                      o_bvalid,
    input  logic                      i_bready,
    output logic [ID_WIDTH-1:0]       o_bid,
    output logic [1:0]                o_bresp,
    input  logic                      i_arvalid,
    output logic                      o_arready,
    input  logic [ID_WIDTH-1:0]       i_arid,
    input  logic [ADDR_WIDTH-1:0]     i_araddr,
    input  logic [7:0]                i_arlen,
    input  logic [2:0]                i_arsize,
    input  logic [1:0]                i_arburst,
    output logic                      o_rvalid,
    input  logic                      i_rready,
    output logic [ID_WIDTH-1:0]       o_rid,
    output logic [DATA_WIDTH-1:0]     o_rdata,
    output logic [1:0]                o_rresp,
    output logic                      o_rlast
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] bytes;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        logic [ADDR_WIDTH-1:0] res;
        bytes     = ADDR_WIDTH'(1) << size;
        incr      = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP:  res = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     res = incr;
        endcase
        return res;
    endfunction

    // Request-level errors poison every beat of the burst.
    function automatic logic req_err(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
        logic bad_wrap_len;
        bad_wrap_len = (burst == BURST_WRAP) &&
                       !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (burst == BURST_RSVD) || (32'(size) > BYTE_SHIFT) || bad_wrap_len;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> BYTE_SHIFT) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] w;
        w = addr >> BYTE_SHIFT;
        return w[IDX_WIDTH-1:0];
    endfunction

    function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
        if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic [1:0]            w_burst_q, w_burst_d, bresp_q, bresp_d;
    logic                  w_err_q, w_err_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [1:0]            r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic                  r_err_q, r_err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;

    logic                  mem_we_c;
    logic [IDX_WIDTH-1:0]  mem_idx_c;
    logic [1:0]            w_beat_resp_c;
    logic                  w_last_c;
    logic                  rd_load_c;
    logic                  rd_err_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;

    // Write engine next-state.
    always_comb begin
        w_state_d     = w_state_q;
        bid_d         = bid_q;
        w_addr_d      = w_addr_q;
        w_len_d       = w_len_q;
        w_cnt_d       = w_cnt_q;
        w_size_d      = w_size_q;
        w_burst_d     = w_burst_q;
        bresp_d       = bresp_q;
        w_err_d       = w_err_q;
        mem_we_c      = 1'b0;
        mem_idx_c     = '0;
        w_beat_resp_c = RESP_OKAY;
        w_last_c      = (w_cnt_q == w_len_q);
        case (w_state_q)
            W_IDLE: begin
                if (i_awvalid && awready_q) begin
                    bid_d     = i_awid;
                    w_addr_d  = i_awaddr;
                    w_len_d   = i_awlen;
                    w_size_d  = i_awsize;
                    w_burst_d = i_awburst;
                    w_cnt_d   = 8'd0;
                    bresp_d   = RESP_OKAY;
                    w_err_d   = req_err(i_awsize, i_awlen, i_awburst);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (i_wvalid && wready_q) begin
                    if (w_err_q) begin
                        w_beat_resp_c = RESP_SLVERR;
                    end else if (!in_range(w_addr_q)) begin
                        w_beat_resp_c = RESP_DECERR;
                    end else begin
                        mem_we_c  = 1'b1;
                        mem_idx_c = word_idx(w_addr_q);
                    end
                    if (w_last_c != i_wlast) w_beat_resp_c = RESP_SLVERR;
                    bresp_d  = merge_resp(bresp_q, w_beat_resp_c);
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_last_c) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (i_bready && bvalid_q) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read engine next-state; rdata is reloaded from the pre-write memory image.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rd_load_c = 1'b0;
        rd_err_c  = r_err_q;
        rd_addr_c = r_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (i_arvalid && arready_q) begin
                    rid_d     = i_arid;
                    r_addr_d  = i_araddr;
                    r_len_d   = i_arlen;
                    r_size_d  = i_arsize;
                    r_burst_d = i_arburst;
                    r_cnt_d   = 8'd0;
                    rd_err_c  = req_err(i_arsize, i_arlen, i_arburst);
                    r_err_d   = rd_err_c;
                    rd_addr_c = i_araddr;
                    rd_load_c = 1'b1;
                    rlast_d   = (i_arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (i_rready && rvalid_q) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rd_addr_c = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
                        r_addr_d  = rd_addr_c;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rd_load_c = 1'b1;
                        rlast_d   = (r_cnt_d == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_load_c) begin
            if (rd_err_c) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else if (!in_range(rd_addr_c)) begin
                rdata_d = '0;
                rresp_d = RESP_DECERR;
            end else begin
                rdata_d = mem_q[word_idx(rd_addr_c)];
                rresp_d = RESP_OKAY;
            end
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            bresp_q   <= RESP_OKAY;
            w_err_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            bresp_q   <= bresp_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Backing store with byte-lane write enables.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we_c) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (i_wstrb[b]) mem_q[mem_idx_c][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_awready = awready_q;
    assign o_wready  = wready_q;
    assign o_bvalid  = bvalid_q;
    assign o_bid     = bid_q;
    assign o_bresp   = bresp_q;
    assign o_arready = arready_q;
    assign o_rvalid  = rvalid_q;
    assign o_rid     = rid_q;
    assign o_rdata   = rdata_q;
    assign o_rresp   = rresp_q;
    assign o_rlast   = rlast_q;

endmodule

// File: tb/tb_tvip_axi_sample_memory_slave.sv
// Directed bench for tvip_axi_sample_memory_slave: bursts, wrap, backpressure, strobes, errors, reset.
module tb_tvip_axi_sample_memory_slave;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_awvalid = 1'b0, o_awready;
    logic [3:0]  i_awid = '0;
    logic [31:0] i_awaddr = '0;
    logic [7:0]  i_awlen = '0;
    logic [2:0]  i_awsize = '0;
    logic [1:0]  i_awburst = '0;
    logic        i_wvalid = 1'b0, o_wready;
    logic [63:0] i_wdata = '0;
    logic [7:0]  i_wstrb = '0;
    logic        i_wlast = 1'b0;
    logic        o_bvalid, i_bready = 1'b0;
    logic [3:0]  o_bid;
    logic [1:0]  o_bresp;
    logic        i_arvalid = 1'b0, o_arready;
    logic [3:0]  i_arid = '0;
    logic [31:0] i_araddr = '0;
    logic [7:0]  i_arlen = '0;
    logic [2:0]  i_arsize = '0;
    logic [1:0]  i_arburst = '0;
    logic        o_rvalid, i_rready = 1'b0;
    logic [3:0]  o_rid;
    logic [63:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rlast;

    int n_checks = 0;
    int n_pass   = 0;

    tvip_axi_sample_memory_slave #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_DEPTH(256)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
        .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_wlast(i_wlast),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr),
        .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
        .o_rresp(o_rresp), .o_rlast(o_rlast)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Handshake drivers: entered and left on a negedge; ok=0 if the DUT never became ready.
    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int k = 0;
        ok = 1'b0;
        i_awvalid = 1'b1; i_awid = id; i_awaddr = addr; i_awlen = len;
        i_awsize = size; i_awburst = burst;
        while (!ok && k < 20) begin
            if (o_awready) begin @(posedge i_clk); ok = 1'b1; end
            @(negedge i_clk); k++;
        end
        i_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int k = 0;
        ok = 1'b0;
        i_arvalid = 1'b1; i_arid = id; i_araddr = addr; i_arlen = len;
        i_arsize = size; i_arburst = burst;
        while (!ok && k < 20) begin
            if (o_arready) begin @(posedge i_clk); ok = 1'b1; end
            @(negedge i_clk); k++;
        end
        i_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                          output bit ok);
        int k = 0;
        ok = 1'b0;
        i_wvalid = 1'b1; i_wdata = data; i_wstrb = strb; i_wlast = last;
        while (!ok && k < 20) begin
            if (o_wready) begin @(posedge i_clk); ok = 1'b1; end
            @(negedge i_clk); k++;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
    endtask

    task automatic get_b(output logic [3:0] id, output logic [1:0] resp, output bit ok);
        int k = 0;
        ok = 1'b0; id = '0; resp = '0;
        i_bready = 1'b1;
        while (!ok && k < 20) begin
            if (o_bvalid) begin id = o_bid; resp = o_bresp; @(posedge i_clk); ok = 1'b1; end
            @(negedge i_clk); k++;
        end
        i_bready = 1'b0;
    endtask

    task automatic get_r(output logic [63:0] d, output logic [1:0] resp, output logic last,
                         output logic [3:0] id, output bit ok);
        int k = 0;
        ok = 1'b0; d = '0; resp = '0; last = 1'b0; id = '0;
        i_rready = 1'b1;
        while (!ok && k < 20) begin
            if (o_rvalid) begin
                d = o_rdata; resp = o_rresp; last = o_rlast; id = o_rid;
                @(posedge i_clk); ok = 1'b1;
            end
            @(negedge i_clk); k++;
        end
        i_rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_awready === 1'b1) n_pass++;
        else $display("FAIL reset_awready: got %b expected 1", o_awready);
        n_checks++; if (o_arready === 1'b1) n_pass++;
        else $display("FAIL reset_arready: got %b expected 1", o_arready);
        n_checks++; if ({o_wready, o_bvalid, o_rvalid} === 3'b000) n_pass++;
        else $display("FAIL reset_valids: got wready/bvalid/rvalid=%b expected 000",
                      {o_wready, o_bvalid, o_rvalid});
        n_checks++; if ({o_bid, o_bresp, o_rid, o_rresp, o_rlast} === 13'd0) n_pass++;
        else $display("FAIL reset_ids: got bid=%h bresp=%b rid=%h rresp=%b rlast=%b expected 0",
                      o_bid, o_bresp, o_rid, o_rresp, o_rlast);
        n_checks++; if (o_rdata === 64'd0) n_pass++;
        else $display("FAIL reset_rdata: got %h expected 0", o_rdata);
    endtask

    task automatic test_incr();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; bit ok;
        send_aw(4'd3, 32'h10, 8'd3, 3'd3, 2'b01, ok);
        for (int b = 0; b < 4; b++) send_w(64'hA0 + 64'(b), 8'hFF, b == 3, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && id === 4'd3 && rs === 2'b00) n_pass++;
        else $display("FAIL incr_b: got ok=%0d id=%h resp=%b expected id=3 resp=00", ok, id, rs);
        send_ar(4'd3, 32'h10, 8'd3, 3'd3, 2'b01, ok);
        for (int b = 0; b < 4; b++) begin
            get_r(d, rs, l, id, ok);
            n_checks++;
            if (ok && d === 64'hA0 + 64'(b) && rs === 2'b00 && l === (b == 3) && id === 4'd3) n_pass++;
            else $display("FAIL incr_r%0d: got ok=%0d data=%h resp=%b last=%b id=%h expected data=%h resp=00 last=%b id=3",
                          b, ok, d, rs, l, id, 64'hA0 + 64'(b), b == 3);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; bit ok;
        logic [63:0] exp_incr [4];
        exp_incr[0] = 64'hB1; exp_incr[1] = 64'hB2; exp_incr[2] = 64'hB3; exp_incr[3] = 64'hB0;
        // Beats land at 0x18, 0x00, 0x08, 0x10.
        send_aw(4'd5, 32'h18, 8'd3, 3'd3, 2'b10, ok);
        for (int b = 0; b < 4; b++) send_w(64'hB0 + 64'(b), 8'hFF, b == 3, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && id === 4'd5 && rs === 2'b00) n_pass++;
        else $display("FAIL wrap_b: got ok=%0d id=%h resp=%b expected id=5 resp=00", ok, id, rs);
        send_ar(4'd6, 32'h0, 8'd3, 3'd3, 2'b01, ok);
        for (int b = 0; b < 4; b++) begin
            get_r(d, rs, l, id, ok);
            n_checks++;
            if (ok && d === exp_incr[b] && rs === 2'b00 && l === (b == 3)) n_pass++;
            else $display("FAIL wrap_incr_r%0d: got ok=%0d data=%h resp=%b last=%b expected data=%h resp=00 last=%b",
                          b, ok, d, rs, l, exp_incr[b], b == 3);
        end
        send_ar(4'd7, 32'h18, 8'd3, 3'd3, 2'b10, ok);
        for (int b = 0; b < 4; b++) begin
            get_r(d, rs, l, id, ok);
            n_checks++;
            if (ok && d === 64'hB0 + 64'(b) && rs === 2'b00 && l === (b == 3) && id === 4'd7) n_pass++;
            else $display("FAIL wrap_r%0d: got ok=%0d data=%h resp=%b last=%b id=%h expected data=%h resp=00 last=%b id=7",
                          b, ok, d, rs, l, id, 64'hB0 + 64'(b), b == 3);
        end
        // Illegal wrap length: SLVERR, no write, zero read data.
        send_aw(4'd2, 32'h100, 8'd2, 3'd3, 2'b10, ok);
        for (int b = 0; b < 3; b++) send_w(64'hC0 + 64'(b), 8'hFF, b == 2, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && id === 4'd2 && rs === 2'b10) n_pass++;
        else $display("FAIL wrap_len2_b: got ok=%0d id=%h resp=%b expected id=2 resp=10", ok, id, rs);
        send_ar(4'd2, 32'h100, 8'd2, 3'd3, 2'b10, ok);
        for (int b = 0; b < 3; b++) begin
            get_r(d, rs, l, id, ok);
            n_checks++;
            if (ok && d === 64'd0 && rs === 2'b10 && l === (b == 2)) n_pass++;
            else $display("FAIL wrap_len2_r%0d: got ok=%0d data=%h resp=%b last=%b expected data=0 resp=10 last=%b",
                          b, ok, d, rs, l, b == 2);
        end
        send_ar(4'd2, 32'h100, 8'd0, 3'd3, 2'b01, ok);
        get_r(d, rs, l, id, ok);
        n_checks++; if (ok && d === 64'd0 && rs === 2'b00 && l === 1'b1) n_pass++;
        else $display("FAIL wrap_len2_nowrite: got ok=%0d data=%h resp=%b last=%b expected data=0 resp=00 last=1",
                      ok, d, rs, l);
    endtask

    task automatic test_backpressure();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; bit ok;
        int beats = 0;
        send_aw(4'd9, 32'h200, 8'd3, 3'd3, 2'b01, ok);
        for (int b = 0; b < 4; b++) send_w(64'hD0 + 64'(b), 8'hFF, b == 3, ok);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (o_bvalid === 1'b1 && o_bid === 4'd9 && o_bresp === 2'b00) n_pass++;
            else $display("FAIL bp_bhold%0d: got bvalid=%b bid=%h bresp=%b expected 1/9/00",
                          c, o_bvalid, o_bid, o_bresp);
            @(negedge i_clk);
        end
        get_b(id, rs, ok);
        n_checks++; if (ok && id === 4'd9 && rs === 2'b00) n_pass++;
        else $display("FAIL bp_b: got ok=%0d id=%h resp=%b expected id=9 resp=00", ok, id, rs);
        send_ar(4'd10, 32'h200, 8'd3, 3'd3, 2'b01, ok);
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int c = 0; c < 5; c++) begin
                    n_checks++;
                    if (o_rvalid === 1'b1 && o_rdata === 64'hD2 && o_rid === 4'd10 && o_rlast === 1'b0) n_pass++;
                    else $display("FAIL bp_rhold%0d: got rvalid=%b data=%h rid=%h rlast=%b expected 1/d2/a/0",
                                  c, o_rvalid, o_rdata, o_rid, o_rlast);
                    @(negedge i_clk);
                end
            end
            get_r(d, rs, l, id, ok);
            if (ok) beats++;
            n_checks++;
            if (ok && d === 64'hD0 + 64'(b) && rs === 2'b00 && l === (b == 3) && id === 4'd10) n_pass++;
            else $display("FAIL bp_r%0d: got ok=%0d data=%h resp=%b last=%b id=%h expected data=%h last=%b id=a",
                          b, ok, d, rs, l, id, 64'hD0 + 64'(b), b == 3);
        end
        @(negedge i_clk);
        n_checks++; if (beats == 4 && o_rvalid === 1'b0) n_pass++;
        else $display("FAIL bp_count: got beats=%0d rvalid=%b expected 4 and 0", beats, o_rvalid);
    endtask

    task automatic test_strobe();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; bit ok;
        send_aw(4'd1, 32'h300, 8'd0, 3'd3, 2'b01, ok);
        send_w(64'h11223344_55667788, 8'h0F, 1'b1, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && rs === 2'b00) n_pass++;
        else $display("FAIL strb_b: got ok=%0d resp=%b expected 00", ok, rs);
        send_ar(4'd1, 32'h300, 8'd0, 3'd3, 2'b01, ok);
        get_r(d, rs, l, id, ok);
        n_checks++; if (ok && d === 64'h00000000_55667788 && rs === 2'b00 && l === 1'b1) n_pass++;
        else $display("FAIL strb_r: got ok=%0d data=%h resp=%b last=%b expected 0000000055667788/00/1",
                      ok, d, rs, l);
    endtask

    task automatic test_errors();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; bit ok;
        send_aw(4'd4, 32'h7F8, 8'd1, 3'd3, 2'b01, ok);
        send_w(64'hE0, 8'hFF, 1'b0, ok);
        send_w(64'hE1, 8'hFF, 1'b1, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && id === 4'd4 && rs === 2'b11) n_pass++;
        else $display("FAIL decerr_b: got ok=%0d id=%h resp=%b expected id=4 resp=11", ok, id, rs);
        send_ar(4'd4, 32'h7F8, 8'd1, 3'd3, 2'b01, ok);
        get_r(d, rs, l, id, ok);
        n_checks++; if (ok && d === 64'hE0 && rs === 2'b00 && l === 1'b0) n_pass++;
        else $display("FAIL decerr_r0: got ok=%0d data=%h resp=%b last=%b expected e0/00/0", ok, d, rs, l);
        get_r(d, rs, l, id, ok);
        n_checks++; if (ok && d === 64'd0 && rs === 2'b11 && l === 1'b1) n_pass++;
        else $display("FAIL decerr_r1: got ok=%0d data=%h resp=%b last=%b expected 0/11/1", ok, d, rs, l);
        send_aw(4'd8, 32'h0, 8'd0, 3'd4, 2'b01, ok);
        send_w(64'hFFFF, 8'hFF, 1'b1, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && rs === 2'b10) n_pass++;
        else $display("FAIL size_b: got ok=%0d resp=%b expected 10", ok, rs);
        send_ar(4'd8, 32'h0, 8'd0, 3'd4, 2'b01, ok);
        get_r(d, rs, l, id, ok);
        n_checks++; if (ok && d === 64'd0 && rs === 2'b10 && l === 1'b1) n_pass++;
        else $display("FAIL size_r: got ok=%0d data=%h resp=%b last=%b expected 0/10/1", ok, d, rs, l);
        // Early wlast on a two-beat burst.
        send_aw(4'd11, 32'h400, 8'd1, 3'd3, 2'b01, ok);
        send_w(64'h1, 8'hFF, 1'b1, ok);
        send_w(64'h2, 8'hFF, 1'b1, ok);
        get_b(id, rs, ok);
        n_checks++; if (ok && id === 4'd11 && rs === 2'b10) n_pass++;
        else $display("FAIL wlast_b: got ok=%0d id=%h resp=%b expected id=b resp=10", ok, id, rs);
    endtask

    task automatic test_reset_mid();
        logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id; bit ok;
        send_aw(4'd12, 32'h500, 8'd3, 3'd3, 2'b01, ok);
        send_w(64'hF0, 8'hFF, 1'b0, ok);
        send_w(64'hF1, 8'hFF, 1'b0, ok);
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_awready === 1'b1 && o_wready === 1'b0 && o_bvalid === 1'b0) n_pass++;
        else $display("FAIL midrst_outs: got awready=%b wready=%b bvalid=%b expected 1/0/0",
                      o_awready, o_wready, o_bvalid);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        send_ar(4'd12, 32'h500, 8'd1, 3'd3, 2'b01, ok);
        for (int b = 0; b < 2; b++) begin
            get_r(d, rs, l, id, ok);
            n_checks++; if (ok && d === 64'd0 && rs === 2'b00 && l === (b == 1)) n_pass++;
            else $display("FAIL midrst_r%0d: got ok=%0d data=%h resp=%b last=%b expected 0/00/%b",
                          b, ok, d, rs, l, b == 1);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_backpressure();
        test_strobe();
        test_errors();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tvip_axi_sample_memory_slave.md
Name: tvip_axi_sample_memory_slave

Overview:
Sample AXI4 responder backed by a word-addressed memory array. It terminates the master side of the sample environment's AXI path, typically downstream of the channel delay insertion logic. Write and read paths are independent, each handling one burst at a time. It returns OKAY, SLVERR or DECERR responses.

Parameters:
ID_WIDTH, 4, width of AWID/BID/ARID/RID
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, data bus width in bits; power of two, 8 to 1024
MEM_DEPTH, 256, number of DATA_WIDTH-bit words; word index = addr >> log2(DATA_WIDTH/8)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_awvalid, i_arvalid  input  1  address valid (write, read)
o_awready, o_arready  output  1  address ready
i_awid, i_arid  input  ID_WIDTH  transaction id
i_awaddr, i_araddr  input  ADDR_WIDTH  start byte address
i_awlen, i_arlen  input  8  beats minus one
i_awsize, i_arsize  input  3  log2 bytes per beat
i_awburst, i_arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
i_wvalid / o_wready  input / output  1  write data handshake
i_wdata  input  DATA_WIDTH  write data
i_wstrb  input  DATA_WIDTH/8  byte-lane strobes
i_wlast  input  1  last write beat
o_bvalid / i_bready  output / input  1  write response handshake
o_bid  output  ID_WIDTH  captured AWID
o_bresp  output  2  00 OKAY, 10 SLVERR, 11 DECERR
o_rvalid / i_rready  output / input  1  read data handshake
o_rid  output  ID_WIDTH  captured ARID
o_rdata  output  DATA_WIDTH  read data
o_rresp  output  2  per-beat response
o_rlast  output  1  final read beat

Behaviour:
- Reset: both FSMs go to IDLE. o_awready and o_arready are 1. o_wready, o_bvalid and o_rvalid are 0. o_bid, o_bresp, o_rid, o_rdata, o_rresp and o_rlast are 0. The memory clears to 0.
- A reset asserted mid-burst aborts the burst immediately; there is no partial response.
- Write FSM, W_IDLE: o_awready=1. On AW handshake, capture id, addr, len, size and burst, then go to W_DATA. o_wready=0 in W_IDLE, so W beats arriving before AW wait.
- Write FSM, W_DATA: o_wready=1. Each W handshake writes the strobed lanes into mem[index(addr)], then the beat address advances.
  - On the beat where the beat counter equals len, go to W_RESP, whatever i_wlast says.
  - If i_wlast=1 early, or is 0 on the final beat, the burst's response becomes SLVERR.
- Write FSM, W_RESP: o_bvalid=1 and o_bid = captured id, held stable until i_bready. Return to W_IDLE on handshake. The earliest next AW acceptance is the cycle after the B handshake.
- Read FSM, R_IDLE: o_arready=1. On AR handshake, capture the request, register o_rdata from mem[index(start addr)], then go to R_DATA.
- Read FSM, R_DATA: o_rvalid=1. o_rid, o_rdata, o_rresp and o_rlast stay stable while i_rready=0.
  - On each R handshake, o_rdata reloads from the next beat address.
  - o_rlast=1 when the beat counter equals len; that handshake returns to R_IDLE.
  - The first beat is valid the cycle after AR acceptance.
- Address advance:
  - FIXED: address unchanged.
  - INCR: (addr aligned down to 2^size) + 2^size; may cross word boundaries.
  - WRAP: increments, then wraps within the (len+1)*2^size aligned block. len must be 1, 3, 7 or 15, otherwise SLVERR.
- Errors, in priority order:
  - Reserved burst, or 2^size > DATA_WIDTH/8: SLVERR for every beat; no memory write; rdata 0.
  - Word index >= MEM_DEPTH on a beat: DECERR for that beat; write dropped; rdata 0.
  - o_bresp is the highest-priority error seen over the burst, with SLVERR above DECERR above OKAY.
- Narrow transfers: writes honour i_wstrb only. Reads return the full word.
- Same-cycle write and read-data load to the same word: the read gets the pre-write value.
- Write and read FSMs run concurrently with no mutual stall.

Test Plan:
- AW(id=3, addr=0x10, len=3, size=3, INCR) with 4 beats of data 0xA0..0xA3 and strb=0xFF, then AR for the same burst -> B: id=3, OKAY; R: 4 beats 0xA0..0xA3, rlast on beat 4, all OKAY.
- WRAP with addr=0x18, len=3, size=3 -> beat addresses 0x18, 0x00, 0x08, 0x10. len=2 with WRAP -> SLVERR on B and on every R beat.
- i_rready held low for 5 cycles mid-burst, with i_bready low for 3 cycles -> rdata, rid and rlast stable; bvalid held; no beat lost or duplicated.
- Write with wstrb=0x0F, data 0x11223344_55667788, over memory holding 0 -> read back 0x00000000_55667788.
- INCR burst starting at the last word (index 255), len=1 -> beat 1 OKAY, beat 2 DECERR; B reports DECERR. Separately, size=4 on a 64-bit bus -> SLVERR.
- Assert i_rst_n mid write burst (2 of 4 beats) -> awready=1, wready=0 and bvalid=0 immediately; a subsequent read of those addresses returns 0.
